pulse_stretcher: RTL

Converts a single-cycle trigger pulse (e.g. the output of an edge detector) back into a level pulse of programmable length, followed by a programmable hold-off (dead time).
Sits downstream of pulse/edge sources to drive LEDs, buzzers, enables and strobes that need a minimum on-time.
Reports busy, end-of-pulse and ignored triggers to the controlling logic.

---
 rtl/pulse_stretcher_if.sv | 13 +
 rtl/pulse_stretcher.sv | 73 +++++++
 2 files changed

// File: rtl/pulse_stretcher_if.sv
// pulse_stretcher_if: trigger/config inputs and status outputs of the pulse stretcher
// master drives trigger/length/holdoff; slave (the stretcher) drives pulse_out/busy/done/missed.
interface pulse_stretcher_if #(parameter int CNT_BITS = 16);
  logic                trigger;
  logic [CNT_BITS-1:0] length;
  logic [CNT_BITS-1:0] holdoff;
  logic                pulse_out;
  logic                busy;
  logic                done;
  logic                missed;
  modport master (output trigger, length, holdoff, input pulse_out, busy, done, missed);
  modport slave (input trigger, length, holdoff, output pulse_out, busy, done, missed);
endinterface

// File: rtl/pulse_stretcher.sv
// pulse_stretcher: stretches a one-cycle trigger into a length-cycle pulse followed by a holdoff dead time
// Ports: clk, rst (async, active-high); s (slave): trigger, length, holdoff in; pulse_out, busy, done, missed out.
// Macro PULSE_STRETCHER_RETRIGGER_EN: a trigger while the pulse is high restarts the length count.
module pulse_stretcher #(parameter int CNT_BITS = 16) (
  input logic clk,
  input logic rst,
  pulse_stretcher_if.slave s
);
  typedef enum logic [1:0] {IDLE, ACTIVE, HOLDOFF} state_t;
  state_t state, state_n;
  logic [CNT_BITS-1:0] cnt, cnt_n, hold_q, hold_n;
  logic pulse_q, pulse_n, done_q, done_n, missed_q, missed_n;
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state <= IDLE;
      cnt <= '0;
      hold_q <= '0;
      pulse_q <= 1'b0;
      done_q <= 1'b0;
      missed_q <= 1'b0;
    end else begin
      state <= state_n;
      cnt <= cnt_n;
      hold_q <= hold_n;
      pulse_q <= pulse_n;
      done_q <= done_n;
      missed_q <= missed_n;
    end
  always_comb begin
    state_n = state;
    cnt_n = cnt;
    hold_n = hold_q;
    pulse_n = 1'b0;
    done_n = 1'b0;
    missed_n = 1'b0;
    case (state)
      IDLE: if (s.trigger && s.length != '0) begin
        state_n = ACTIVE;
        cnt_n = s.length - 1'b1;
        hold_n = s.holdoff;
        pulse_n = 1'b1;
      end
      ACTIVE: begin
        pulse_n = cnt != '0;
        done_n = cnt == '0;
        missed_n = s.trigger;
        cnt_n = cnt != '0 ? cnt - 1'b1 : hold_q != '0 ? hold_q - 1'b1 : '0;
        state_n = cnt != '0 ? ACTIVE : hold_q != '0 ? HOLDOFF : IDLE;
`ifdef PULSE_STRETCHER_RETRIGGER_EN
        // A valid retrigger overrides the end-of-pulse decision above.
        if (s.trigger && s.length != '0) begin
          state_n = ACTIVE;
          cnt_n = s.length - 1'b1;
          hold_n = s.holdoff;
          pulse_n = 1'b1;
          done_n = 1'b0;
          missed_n = 1'b0;
        end
`endif
      end
      HOLDOFF: begin
        missed_n = s.trigger;
        cnt_n = cnt != '0 ? cnt - 1'b1 : '0;
        state_n = cnt != '0 ? HOLDOFF : IDLE;
      end
      default: state_n = IDLE;
    endcase
  end
  assign s.pulse_out = pulse_q;
  assign s.busy = state != IDLE;
  assign s.done = done_q;
  assign s.missed = missed_q;
endmodule
